program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Host-side initiator for the CPU's external program-memory write port (ext_wen / ext_addr / ext_data).
- Accepts a framed byte stream over a valid/ready handshake and assembles 16-bit instruction words.
- Writes each word into memory at consecutive addresses starting at 0.
- After a verified load, asserts timer_en to release the CPU timing generator. On a bad frame, the CPU is held stopped.

Parameters:
- HDR_BYTE, 8'hA5, frame header value.
- ADDR_W, 8, width of ext_addr; also the width of the word-count field.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin or restart a load.
- in_byte  input  8  stream byte.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  loader accepts in_byte this cycle; a transfer occurs when in_valid and in_ready are both 1.
- ext_wen  output  1  one-cycle write strobe to program memory.
- ext_addr  output  ADDR_W  write address.
- ext_data  output  16  write data.
- timer_en  output  1  CPU run enable.
- busy  output  1  load in progress.
- err  output  1  frame error, sticky until start.
- word_count  output  ADDR_W  number of words written in the current frame.

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. Reset applied mid-load aborts immediately; words already written stay in memory.
- Frame format, in order:
  - HDR_BYTE.
  - N, the word count, legal range 1..255.
  - N word pairs, each sent high byte first, then low byte.
  - CHK, equal to the XOR of all 2N data bytes.
- State machine:
  - IDLE: wait for start.
  - HDR: on a byte equal to HDR_BYTE, go to LEN. Any other byte is discarded and the state stays HDR (resync; not an error).
  - LEN: N=0 goes to ERR. Otherwise latch N, clear the address pointer, word_count and XOR accumulator, then go to HI.
  - HI: latch the high byte and fold it into the XOR; go to LO.
  - LO: latch the low byte and fold it into the XOR; go to WR.
  - WR: for exactly one cycle, ext_wen=1, ext_addr=pointer, ext_data={hi,lo}. Then increment the pointer and word_count. If word_count has reached N, go to CHK; otherwise go to HI.
  - CHK: a byte equal to the accumulator goes to RUN; a mismatch goes to ERR.
  - RUN: timer_en=1, held until the next start.
  - ERR: err=1, timer_en=0, held until start.
- in_ready is 1 only in HDR, LEN, HI, LO and CHK; it is 0 in IDLE, WR, RUN and ERR.
- Latency: a low byte accepted at the edge ending cycle t gives ext_wen=1 in cycle t+1. in_ready returns in cycle t+2.
- Peak write rate is one word per 3 cycles. Gaps in in_valid stall the state machine with no side effects.
- ext_addr and ext_data are registered and hold their last values while ext_wen=0.
- busy=1 in the states HDR through CHK.
- start in any state, including mid-load, RUN or ERR:
  - the next state is HDR;
  - err and timer_en clear on the following edge;
  - word_count clears on the following edge.
- A start and a byte in the same cycle: the byte is not accepted. in_ready is forced to 0 that cycle.
- Address wrap: with N≤255 the pointer never exceeds 254, so it cannot wrap.
- ext_wen is never asserted outside WR. ext_wen and timer_en are never both 1.

Decomposition:
- Shared package:
  - state enumeration (IDLE, HDR, LEN, HI, LO, WR, CHK, RUN, ERR);
  - HDR_BYTE default;
  - ADDR_W.
- One natural sub-module, loader_word_asm:
  - takes a byte, a hi/lo select and a clear;
  - produces the assembled 16-bit word and the running XOR checksum.
- The FSM, pointer and counters stay in program_loader.

Test Plan:
1. Load, gap-free: start, then A5 02 12 34 AB CD 40 → ext_wen pulses:
   - addr 0 with 16'h1234;
   - addr 1 with 16'hABCD.
   Then timer_en=1, err=0, word_count=2.
2. Bad checksum and recovery: same frame with CHK=41 → both writes occur, err=1, timer_en=0. A new start clears err. A good frame then reaches RUN.
3. Resync and zero length:
   - 00 FF then a good frame → the two junk bytes are ignored and the load completes.
   - Separately, A5 00 → ERR with no ext_wen.
4. Backpressure: in_valid toggled randomly during a 255-word frame → exactly 255 writes at addr 0..254, in order. in_ready is 0 in each cycle after a low byte. Correct CHK gives RUN.
5. Abort cases:
   - rst_n low after the 3rd word → all outputs 0 asynchronously.
   - start mid-frame → returns to HDR with word_count=0; the following frame loads from addr 0.
6. Start while RUN: timer_en drops the cycle after start and in_ready=1 in HDR. A start coincident with in_valid is not consumed as data.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types and defaults for the program loader slice.
package program_loader_pkg;

    localparam int unsigned DEF_ADDR_W   = 8;
    localparam logic [7:0]  DEF_HDR_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_LEN,
        S_HI,
        S_LO,
        S_WR,
        S_CHK,
        S_RUN,
        S_ERR
    } state_t;

    // States in which a stream byte may be taken.
    function automatic logic accepts_byte(input state_t s);
        return s inside {S_HDR, S_LEN, S_HI, S_LO, S_CHK};
    endfunction

    // States that make up an in-progress load.
    function automatic logic is_loading(input state_t s);
        return s inside {S_HDR, S_LEN, S_HI, S_LO, S_WR, S_CHK};
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream (valid/ready) and program-memory write port of the loader.
interface program_loader_if
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
);
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              ext_wen;
    logic [ADDR_W-1:0] ext_addr;
    logic [15:0]       ext_data;

    modport master (
        output in_byte, in_valid,
        input  in_ready, ext_wen, ext_addr, ext_data
    );

    modport slave (
        input  in_byte, in_valid,
        output in_ready, ext_wen, ext_addr, ext_data
    );
endinterface

// File: rtl/program_loader_word_asm.sv
// Assembles a 16-bit word from high/low bytes and keeps the running XOR of all data bytes.
module loader_word_asm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        load,
    input  logic        sel_lo,
    input  logic [7:0]  data,
    output logic [15:0] word,
    output logic [7:0]  csum
);
    logic [7:0] hi_q;

    // The word is presented while the low byte is on the input so the caller can register it in the same edge.
    assign word = {hi_q, data};

    // Latch the high byte and fold every loaded byte into the checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            csum <= '0;
        end else if (clear) begin
            hi_q <= '0;
            csum <= '0;
        end else if (load) begin
            csum <= csum ^ data;
            if (!sel_lo) begin
                hi_q <= data;
            end
        end
    end
endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader that writes 16-bit words into program memory and releases the CPU after a good checksum.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [7:0]  HDR_BYTE = DEF_HDR_BYTE,
    parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    program_loader_if.slave   bus,
    output logic              timer_en,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] word_count
);
    state_t            state;
    logic [ADDR_W-1:0] n_q;
    logic [ADDR_W-1:0] count_inc;
    logic              xfer;
    logic              asm_clear;
    logic              asm_load;
    logic              asm_sel_lo;
    logic [15:0]       asm_word;
    logic [7:0]        asm_csum;

    // A start in the same cycle as a byte wins; the byte is refused.
    assign bus.in_ready = !start && accepts_byte(state);
    assign xfer         = bus.in_valid && bus.in_ready;

    assign asm_clear  = xfer && (state == S_LEN) && (bus.in_byte != 8'h00);
    assign asm_load   = xfer && ((state == S_HI) || (state == S_LO));
    assign asm_sel_lo = (state == S_LO);

    assign timer_en = (state == S_RUN);
    assign err      = (state == S_ERR);
    assign busy     = is_loading(state);

    // word_count doubles as the write pointer; N <= 255 keeps it at most 254 when used as an address.
    assign count_inc = word_count + ADDR_W'(1);

    loader_word_asm u_word_asm (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (asm_clear),
        .load   (asm_load),
        .sel_lo (asm_sel_lo),
        .data   (bus.in_byte),
        .word   (asm_word),
        .csum   (asm_csum)
    );

    // Frame parser: header, length, word pairs with write strobe, checksum, then run or error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            n_q          <= '0;
            word_count   <= '0;
            bus.ext_wen  <= 1'b0;
            bus.ext_addr <= '0;
            bus.ext_data <= '0;
        end else begin
            bus.ext_wen <= 1'b0;
            if (start) begin
                state      <= S_HDR;
                word_count <= '0;
            end else begin
                case (state)
                    S_HDR: begin
                        if (xfer && (bus.in_byte == HDR_BYTE)) begin
                            state <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (xfer) begin
                            if (bus.in_byte == 8'h00) begin
                                state <= S_ERR;
                            end else begin
                                n_q        <= ADDR_W'(bus.in_byte);
                                word_count <= '0;
                                state      <= S_HI;
                            end
                        end
                    end
                    S_HI: begin
                        if (xfer) begin
                            state <= S_LO;
                        end
                    end
                    S_LO: begin
                        // Strobe is raised here so it is high for exactly the WR cycle.
                        if (xfer) begin
                            bus.ext_wen  <= 1'b1;
                            bus.ext_addr <= word_count;
                            bus.ext_data <= asm_word;
                            state        <= S_WR;
                        end
                    end
                    S_WR: begin
                        word_count <= count_inc;
                        state      <= (count_inc == n_q) ? S_CHK : S_HI;
                    end
                    S_CHK: begin
                        if (xfer) begin
                            state <= (bus.in_byte == asm_csum) ? S_RUN : S_ERR;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a frame-level scoreboard of expected memory writes.
`timescale 1ns/1ps
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       timer_en;
    logic       busy;
    logic       err;
    logic [7:0] word_count;

    program_loader_if #(.ADDR_W(8)) bus ();

    program_loader #(.HDR_BYTE(8'hA5), .ADDR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .timer_en   (timer_en),
        .busy       (busy),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    int          vectors     = 0;
    int          miscompares = 0;
    wr_t         exp_q[$];
    logic [7:0]  acc;
    logic [15:0] words [0:254];
    int          lo_sent     = 0;
    int          lo_handled  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wen"},   32'(bus.ext_wen),   32'd0);
        check({tag, "_addr"},  32'(bus.ext_addr),  32'd0);
        check({tag, "_data"},  32'(bus.ext_data),  32'd0);
        check({tag, "_timer"}, 32'(timer_en),      32'd0);
        check({tag, "_busy"},  32'(busy),          32'd0);
        check({tag, "_err"},   32'(err),           32'd0);
        check({tag, "_wc"},    32'(word_count),    32'd0);
        check({tag, "_ready"}, 32'(bus.in_ready),  32'd0);
    endtask

    // Scoreboard: every write strobe must match the next expected (addr, data); write latency and mutual exclusion are checked each cycle.
    always @(negedge clk) begin : compare
        wr_t e;
        if (bus.ext_wen) begin
            if (exp_q.size() == 0) begin
                check("spurious_wen", 32'(bus.ext_wen), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.ext_addr), 32'(e.addr));
                check("wr_data", 32'(bus.ext_data), 32'(e.data));
            end
        end
        if (lo_sent != lo_handled) begin
            check("wen_after_lo",   32'(bus.ext_wen),  32'd1);
            check("ready_after_lo", 32'(bus.in_ready), 32'd0);
            lo_handled = lo_sent;
        end
        if (bus.ext_wen || timer_en) begin
            check("wen_timer_excl", 32'(bus.ext_wen & timer_en), 32'd0);
        end
    end

    // Called shortly after a rising edge; returns 1 time unit after the edge that took the byte.
    task automatic send_byte(input logic [7:0] b, input bit is_lo, input bit gaps);
        int unsigned guard = 0;
        if (gaps) begin
            int unsigned idle = $urandom_range(0, 2);
            for (int unsigned i = 0; i < idle; i++) begin
                bus.in_byte = 8'($urandom);
                @(posedge clk);
                #1;
            end
        end
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && guard < 40) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (guard == 40) begin
            check("ready_timeout", 32'(bus.in_ready), 32'd1);
        end else begin
            @(posedge clk);
            if (is_lo) lo_sent++;
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_words(input int unsigned first, input int unsigned count, input bit gaps);
        wr_t e;
        for (int unsigned i = first; i < first + count; i++) begin
            e.addr = 8'(i);
            e.data = words[i];
            exp_q.push_back(e);
            acc = acc ^ words[i][15:8] ^ words[i][7:0];
            send_byte(words[i][15:8], 1'b0, gaps);
            send_byte(words[i][7:0],  1'b1, gaps);
        end
    endtask

    task automatic run_frame(input int unsigned n, input logic [7:0] chk_delta, input bit gaps);
        acc = 8'h00;
        send_byte(8'hA5, 1'b0, gaps);
        send_byte(8'(n), 1'b0, gaps);
        send_words(0, n, gaps);
        send_byte(acc ^ chk_delta, 1'b0, gaps);
        check("frame_timer_en", 32'(timer_en),     32'(chk_delta == 8'h00));
        check("frame_err",      32'(err),          32'(chk_delta != 8'h00));
        check("frame_busy",     32'(busy),         32'd0);
        check("frame_wc",       32'(word_count),   32'(n));
        check("frame_drained",  32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_start(input bit with_valid);
        start = 1'b1;
        if (with_valid) begin
            bus.in_valid = 1'b1;
            bus.in_byte  = 8'hA5;
        end
        #1;
        check("ready_during_start", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("start_wc",    32'(word_count),   32'd0);
        check("start_err",   32'(err),          32'd0);
        check("start_timer", 32'(timer_en),     32'd0);
        check("start_busy",  32'(busy),         32'd1);
        check("start_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst_n        = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic two-word load.
        words[0] = 16'h1234;
        words[1] = 16'hABCD;
        pulse_start(1'b0);
        run_frame(2, 8'h00, 1'b0);
        check("t1_model_chk", 32'(acc),          32'h40);
        check("t1_timer_en",  32'(timer_en),     32'd1);
        check("t1_wc",        32'(word_count),   32'd2);
        check("t1_addr_hold", 32'(bus.ext_addr), 32'd1);
        check("t1_data_hold", 32'(bus.ext_data), 32'hABCD);

        // Bad checksum (0x41) then recovery.
        pulse_start(1'b0);
        run_frame(2, 8'h01, 1'b0);
        check("t2_err", 32'(err), 32'd1);
        pulse_start(1'b0);
        run_frame(2, 8'h00, 1'b0);

        // Junk before the header is skipped.
        words[0] = 16'h0001;
        words[1] = 16'h8000;
        words[2] = 16'hA5A5;
        pulse_start(1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'hFF, 1'b0, 1'b0);
        check("t3_junk_wc",   32'(word_count), 32'd0);
        check("t3_junk_busy", 32'(busy),       32'd1);
        run_frame(3, 8'h00, 1'b0);

        // Zero length frame.
        pulse_start(1'b0);
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        check("t3_zero_err",    32'(err),          32'd1);
        check("t3_zero_timer",  32'(timer_en),     32'd0);
        check("t3_zero_busy",   32'(busy),         32'd0);
        check("t3_zero_writes", 32'(exp_q.size()), 32'd0);

        // Full-size frame with random stalls.
        for (int unsigned i = 0; i < 255; i++) words[i] = 16'($urandom);
        pulse_start(1'b0);
        run_frame(255, 8'h00, 1'b1);
        check("t4_last_addr", 32'(bus.ext_addr), 32'd254);
        check("t4_last_data", 32'(bus.ext_data), 32'(words[254]));

        // Asynchronous reset after the third word.
        pulse_start(1'b0);
        acc = 8'h00;
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        send_words(0, 3, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort_rst");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(bus.in_ready), 32'd0);

        // Start mid-frame, then a fresh frame loads from address 0.
        pulse_start(1'b0);
        acc = 8'h00;
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(8'h04, 1'b0, 1'b0);
        send_words(0, 2, 1'b0);
        pulse_start(1'b0);
        words[0] = 16'hDEAD;
        words[1] = 16'hBEEF;
        words[2] = 16'h0F0F;
        run_frame(3, 8'h00, 1'b0);

        // Start while running, coincident with a valid byte.
        check("t6_running", 32'(timer_en), 32'd1);
        pulse_start(1'b1);
        words[0] = 16'h55AA;
        run_frame(1, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
